// File: rtl/exmem_pkg.sv
// rtl/exmem_pkg.sv - shared constants and types for the EX/MEM pipeline stage
package exmem_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Instruction word loaded when the stage is squashed or reset
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Default BUSY-cycle budget before a data-memory access is declared hung
    localparam int MEM_TIMEOUT_DEFAULT = 15;

    // Control bits carried through the stage, packed so one register holds them
    typedef struct packed {
        logic       reg_we;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       create_dump;
        logic       err;
        logic [1:0] wsel;
    } ctrl_t;

endpackage

// File: rtl/exmem_stage_nbitreg.sv
// rtl/exmem_stage_nbitreg.sv - N-bit enabled register with asynchronous reset value
// Ports: clk, rst (async, active-high), en_i (load enable), d_i (next value), q_o (stored value)
module nBitRegister #(
    parameter int             N         = 16,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline stage with data-memory handshake FSM
// Ports: clk/rst; ID/EX operands and control (*_in, Flush); data-memory request
// (mem_addr, mem_wdata, mem_en, mem_wr, mem_rdata, mem_done); MEM/WB values
// (*_out, wb_valid); Stall_out back-pressure upstream; err sticky error flag.
module exmem_stage
    import exmem_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Flush,
    input  logic [15:0] Instruction_in,
    input  logic [15:0] PCplus2_in,
    input  logic [15:0] ALUResult_in,
    input  logic [15:0] StoreData_in,
    input  logic        RegWriteEnable_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        CreateDump_in,
    input  logic        Err_in,
    input  logic [1:0]  WriteRegSel_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic [15:0] Instruction_out,
    output logic [15:0] PCplus2_out,
    output logic [15:0] ALUResult_out,
    output logic [15:0] MemData_out,
    output logic        RegWriteEnable_out,
    output logic        MemToReg_out,
    output logic        CreateDump_out,
    output logic        Err_out,
    output logic        wb_valid,
    output logic [1:0]  WriteRegSel_out,
    output logic        Stall_out,
    output logic        err
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic        err_q, err_d;
    logic        busy_q;
    logic        capture;
    logic        squash;
    logic        illegal_in;
    logic        memop_in;
    logic        wb_d;
    logic [0:0]  wb_q;
    logic [15:0] instr_d;
    ctrl_t       ctrl_d, ctrl_q;

    assign busy_q    = (state_q == ST_BUSY);
    assign Stall_out = busy_q & ~mem_done;
    assign capture   = ~Stall_out;

    // An access already in flight is committed, so Flush only squashes from IDLE
    assign squash     = Flush & ~busy_q;
    assign illegal_in = MemRead_in & MemWrite_in & ~squash;
    assign memop_in   = (MemRead_in ^ MemWrite_in) & ~squash;

    assign instr_d = squash ? NOP_INSTR : Instruction_in;

    always_comb begin
        ctrl_d = '0;
        if (!squash) begin
            ctrl_d.reg_we      = RegWriteEnable_in;
            ctrl_d.mem_to_reg  = MemToReg_in;
            ctrl_d.mem_read    = MemRead_in;
            ctrl_d.mem_write   = MemWrite_in;
            ctrl_d.create_dump = CreateDump_in;
            ctrl_d.err         = Err_in | illegal_in;
            ctrl_d.wsel        = WriteRegSel_in;
        end
    end

    // Stage registers, all advancing together when the stage is not stalled
    nBitRegister #(.N(16), .RESET_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .en_i(capture), .d_i(instr_d), .q_o(Instruction_out));
    nBitRegister #(.N(16)) u_pc (
        .clk(clk), .rst(rst), .en_i(capture), .d_i(PCplus2_in), .q_o(PCplus2_out));
    nBitRegister #(.N(16)) u_alu (
        .clk(clk), .rst(rst), .en_i(capture), .d_i(ALUResult_in), .q_o(ALUResult_out));
    nBitRegister #(.N(16)) u_sdata (
        .clk(clk), .rst(rst), .en_i(capture), .d_i(StoreData_in), .q_o(mem_wdata));
    nBitRegister #(.N($bits(ctrl_t))) u_ctrl (
        .clk(clk), .rst(rst), .en_i(capture), .d_i(ctrl_d), .q_o(ctrl_q));

    // Read data is taken only when a read completes; a store leaves it untouched
    nBitRegister #(.N(16)) u_mdata (
        .clk(clk), .rst(rst), .en_i(capture & busy_q & ctrl_q.mem_read),
        .d_i(mem_rdata), .q_o(MemData_out));

    // Retirement pulse: a completing access, or a captured non-memory, non-NOP op.
    // Loaded every cycle so it cannot stay high through a stall.
    assign wb_d = capture & (busy_q | (~squash & ~memop_in & (Instruction_in != NOP_INSTR)));

    nBitRegister #(.N(1)) u_wb (
        .clk(clk), .rst(rst), .en_i(1'b1), .d_i(wb_d), .q_o(wb_q));

    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (capture) begin
            state_d = memop_in ? ST_BUSY : ST_IDLE;
            if (memop_in) begin
                cnt_d = 4'd0;
            end
            if (illegal_in) begin
                err_d = 1'b1;
            end
        end else begin
            // Stalled implies BUSY without mem_done: count and watch the budget
            cnt_d = cnt_inc;
            if (cnt_inc >= TIMEOUT_CNT) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_en             = busy_q;
    assign mem_wr             = busy_q & ctrl_q.mem_write;
    assign mem_addr           = ALUResult_out;
    assign RegWriteEnable_out = ctrl_q.reg_we;
    assign MemToReg_out       = ctrl_q.mem_to_reg;
    assign CreateDump_out     = ctrl_q.create_dump;
    assign Err_out            = ctrl_q.err;
    assign WriteRegSel_out    = ctrl_q.wsel;
    assign wb_valid           = wb_q[0];
    assign err                = err_q;

endmodule

// File: tb/tb_exmem_stage.sv
// tb/tb_exmem_stage.sv - self-checking bench for exmem_stage
module tb_exmem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Flush;
    logic [15:0] Instruction_in, PCplus2_in, ALUResult_in, StoreData_in;
    logic        RegWriteEnable_in, MemToReg_in, MemRead_in, MemWrite_in, CreateDump_in, Err_in;
    logic [1:0]  WriteRegSel_in;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_done;
    logic [15:0] Instruction_out, PCplus2_out, ALUResult_out, MemData_out;
    logic        RegWriteEnable_out, MemToReg_out, CreateDump_out, Err_out, wb_valid;
    logic [1:0]  WriteRegSel_out;
    logic        Stall_out, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exmem_stage #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .Instruction_in(Instruction_in), .PCplus2_in(PCplus2_in),
        .ALUResult_in(ALUResult_in), .StoreData_in(StoreData_in),
        .RegWriteEnable_in(RegWriteEnable_in), .MemToReg_in(MemToReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .CreateDump_in(CreateDump_in), .Err_in(Err_in), .WriteRegSel_in(WriteRegSel_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .Instruction_out(Instruction_out), .PCplus2_out(PCplus2_out),
        .ALUResult_out(ALUResult_out), .MemData_out(MemData_out),
        .RegWriteEnable_out(RegWriteEnable_out), .MemToReg_out(MemToReg_out),
        .CreateDump_out(CreateDump_out), .Err_out(Err_out), .wb_valid(wb_valid),
        .WriteRegSel_out(WriteRegSel_out), .Stall_out(Stall_out), .err(err)
    );

    typedef struct {
        logic        flush;
        logic [15:0] instr;
        logic [15:0] alu;
        logic        rd, wr, regwe, dump, errin;
        logic [1:0]  wsel;
        logic [15:0] e_instr;
        logic        chk_data;
        logic [15:0] e_alu;
        logic        e_regwe, e_dump, e_errout;
        logic [1:0]  e_wsel;
        logic        e_wb, e_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic bubble();
        Flush = 0; Instruction_in = 16'h0800; PCplus2_in = 0; ALUResult_in = 0; StoreData_in = 0;
        RegWriteEnable_in = 0; MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        CreateDump_in = 0; Err_in = 0; WriteRegSel_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_instr"}, Instruction_out, 16'h0800);
        chk({tag, "_alu"}, ALUResult_out, 16'h0000);
        chk({tag, "_pc"}, PCplus2_out, 16'h0000);
        chk({tag, "_mdata"}, MemData_out, 16'h0000);
        chk({tag, "_ctrl"}, {11'd0, RegWriteEnable_out, MemToReg_out, CreateDump_out, Err_out, wb_valid}, 16'h0000);
        chk({tag, "_wsel"}, {14'd0, WriteRegSel_out}, 16'h0000);
        chk({tag, "_mem"}, {14'd0, mem_en, mem_wr}, 16'h0000);
        chk({tag, "_stall"}, {15'd0, Stall_out}, 16'h0000);
        chk({tag, "_err"}, {15'd0, err}, 16'h0000);
    endtask

    initial begin
        int stall_cnt;

        //          flush instr     alu      rd wr we dp er ws  e_instr  chk e_alu    we dp eo ws wb err
        vecs[0] = '{1'b0, 16'h4123, 16'h1234, 0, 0, 1, 0, 0, 2, 16'h4123, 1, 16'h1234, 1, 0, 0, 2, 1, 0};
        vecs[1] = '{1'b1, 16'h4567, 16'h5555, 0, 0, 1, 0, 0, 3, 16'h0800, 0, 16'h0000, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{1'b0, 16'h0000, 16'h0007, 0, 0, 0, 1, 1, 1, 16'h0000, 1, 16'h0007, 0, 1, 1, 1, 1, 0};
        vecs[3] = '{1'b0, 16'h0800, 16'h0009, 0, 0, 0, 0, 0, 0, 16'h0800, 1, 16'h0009, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{1'b1, 16'h8042, 16'h0042, 0, 1, 0, 0, 0, 0, 16'h0800, 0, 16'h0000, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 16'h6001, 16'h0001, 0, 0, 1, 1, 1, 2, 16'h0800, 0, 16'h0000, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{1'b0, 16'h9abc, 16'h0010, 1, 1, 1, 0, 0, 1, 16'h9abc, 1, 16'h0010, 1, 0, 1, 1, 1, 1};

        bubble();
        mem_done = 0; mem_rdata = 0;
        rst = 1;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 0;

        // Single-capture vectors applied from IDLE
        for (int i = 0; i < 7; i++) begin
            bubble();
            Flush = vecs[i].flush; Instruction_in = vecs[i].instr; ALUResult_in = vecs[i].alu;
            MemRead_in = vecs[i].rd; MemWrite_in = vecs[i].wr; RegWriteEnable_in = vecs[i].regwe;
            CreateDump_in = vecs[i].dump; Err_in = vecs[i].errin; WriteRegSel_in = vecs[i].wsel;
            tick();
            chk($sformatf("v%0d_instr", i), Instruction_out, vecs[i].e_instr);
            if (vecs[i].chk_data) chk($sformatf("v%0d_alu", i), ALUResult_out, vecs[i].e_alu);
            chk($sformatf("v%0d_regwe", i), {15'd0, RegWriteEnable_out}, {15'd0, vecs[i].e_regwe});
            chk($sformatf("v%0d_dump", i), {15'd0, CreateDump_out}, {15'd0, vecs[i].e_dump});
            chk($sformatf("v%0d_errout", i), {15'd0, Err_out}, {15'd0, vecs[i].e_errout});
            chk($sformatf("v%0d_wsel", i), {14'd0, WriteRegSel_out}, {14'd0, vecs[i].e_wsel});
            chk($sformatf("v%0d_wb", i), {15'd0, wb_valid}, {15'd0, vecs[i].e_wb});
            chk($sformatf("v%0d_err", i), {15'd0, err}, {15'd0, vecs[i].e_err});
            chk($sformatf("v%0d_memen", i), {15'd0, mem_en}, 16'h0000);
            chk($sformatf("v%0d_stall", i), {15'd0, Stall_out}, 16'h0000);
        end
        bubble();
        tick();
        chk("illegal_sticky_err", {15'd0, err}, 16'h0001);
        chk("illegal_no_busy", {15'd0, mem_en}, 16'h0000);

        rst = 1;
        #1;
        check_reset_values("rst2");
        @(negedge clk);
        rst = 0;

        // ADD followed by no memory op
        bubble();
        Instruction_in = 16'hd9a0; PCplus2_in = 16'h0102; ALUResult_in = 16'h1234; RegWriteEnable_in = 1;
        tick();
        chk("add_wb", {15'd0, wb_valid}, 16'h0001);
        chk("add_alu", ALUResult_out, 16'h1234);
        chk("add_pc", PCplus2_out, 16'h0102);
        chk("add_stall", {15'd0, Stall_out}, 16'h0000);
        bubble();
        tick();
        chk("add_wb_once", {15'd0, wb_valid}, 16'h0000);
        chk("add_stall2", {15'd0, Stall_out}, 16'h0000);

        // LD with mem_done after three stalled cycles
        Instruction_in = 16'h8840; ALUResult_in = 16'h0040; MemRead_in = 1; MemToReg_in = 1;
        RegWriteEnable_in = 1;
        tick();
        bubble();
        chk("ld_memen", {15'd0, mem_en}, 16'h0001);
        chk("ld_addr", mem_addr, 16'h0040);
        chk("ld_memwr", {15'd0, mem_wr}, 16'h0000);
        chk("ld_memtoreg", {15'd0, MemToReg_out}, 16'h0001);
        stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                mem_done = 1; mem_rdata = 16'hBEEF;
            end
            #1;
            if (Stall_out) stall_cnt++;
            chk($sformatf("ld_wb_c%0d", c), {15'd0, wb_valid}, 16'h0000);
            chk($sformatf("ld_addr_c%0d", c), mem_addr, 16'h0040);
            tick();
        end
        mem_done = 0; mem_rdata = 16'h0;
        chk("ld_stall_cycles", 16'(stall_cnt), 16'd3);
        chk("ld_mdata", MemData_out, 16'hBEEF);
        chk("ld_wb", {15'd0, wb_valid}, 16'h0001);
        chk("ld_idle", {15'd0, mem_en}, 16'h0000);
        tick();
        chk("ld_wb_once", {15'd0, wb_valid}, 16'h0000);
        chk("ld_mdata_hold", MemData_out, 16'hBEEF);

        // ST followed back-to-back by LD
        Instruction_in = 16'h8100; ALUResult_in = 16'h0100; StoreData_in = 16'hA5A5; MemWrite_in = 1;
        tick();
        bubble();
        chk("st_memwr", {15'd0, mem_wr}, 16'h0001);
        chk("st_wdata", mem_wdata, 16'hA5A5);
        Instruction_in = 16'h8a00; ALUResult_in = 16'h0200; MemRead_in = 1; RegWriteEnable_in = 1;
        mem_done = 1;
        #1;
        chk("st_done_stall", {15'd0, Stall_out}, 16'h0000);
        tick();
        mem_done = 0;
        bubble();
        chk("b2b_busy", {15'd0, mem_en}, 16'h0001);
        chk("b2b_memwr_drop", {15'd0, mem_wr}, 16'h0000);
        chk("b2b_addr", mem_addr, 16'h0200);
        chk("b2b_st_wb", {15'd0, wb_valid}, 16'h0001);
        chk("b2b_mdata_hold", MemData_out, 16'hBEEF);
        tick();
        chk("b2b_wb_stalled", {15'd0, wb_valid}, 16'h0000);
        chk("b2b_stall", {15'd0, Stall_out}, 16'h0001);
        mem_done = 1; mem_rdata = 16'h1111;
        tick();
        mem_done = 0;
        chk("b2b_ld_mdata", MemData_out, 16'h1111);
        chk("b2b_ld_wb", {15'd0, wb_valid}, 16'h0001);
        chk("b2b_idle", {15'd0, mem_en}, 16'h0000);

        // mem_done while IDLE is ignored
        mem_done = 1; mem_rdata = 16'h7777;
        tick();
        mem_done = 0;
        chk("idle_done_mdata", MemData_out, 16'h1111);
        chk("idle_done_wb", {15'd0, wb_valid}, 16'h0000);

        // LD that never completes
        Instruction_in = 16'h8844; ALUResult_in = 16'h0044; MemRead_in = 1;
        tick();
        bubble();
        for (int c = 0; c < 14; c++) tick();
        chk("to_err_early", {15'd0, err}, 16'h0000);
        tick();
        chk("to_err", {15'd0, err}, 16'h0001);
        chk("to_stall", {15'd0, Stall_out}, 16'h0001);
        for (int c = 0; c < 3; c++) tick();
        chk("to_err_held", {15'd0, err}, 16'h0001);
        chk("to_busy_held", {15'd0, mem_en}, 16'h0001);
        rst = 1;
        #1;
        check_reset_values("to_rst");
        @(negedge clk);
        rst = 0;
        tick();
        chk("to_no_wb", {15'd0, wb_valid}, 16'h0000);
        chk("to_post_memen", {15'd0, mem_en}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
